// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath: default widths, bus float value
// and the decoded program-counter operation.
package sap_pkg;

  localparam int SAP_ADDR_WIDTH = 4;
  localparam int SAP_BUS_WIDTH  = 8;

  // One bit of an undriven bus; replicate to the required width.
  localparam logic SAP_HIZ = 1'bz;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

  // Priority decode of the controller strobes: Ret > Call > Lp > Cp > hold.
  function automatic op_e decode_op(input logic cp, input logic lp,
                                    input logic call, input logic ret);
    op_e op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (lp)   op = OP_LOAD;
    else if (cp)   op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Parametrised return-address LIFO built from registers. Pushes while full
// and pops while empty are silently dropped; the pointer is one bit wider
// than the index so full and empty are distinct states.
module ret_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-2:0]    w_wr_idx;
  logic [PW-2:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_ptr == PW'(DEPTH));
  assign empty     = (r_ptr == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop && !full;
  assign w_wr_idx  = r_ptr[PW-2:0];
  assign w_top_idx = r_ptr[PW-2:0] - (PW-1)'(1);
  assign dout      = r_mem[w_top_idx];

  // Stack pointer: cleared by reset, moves by one on a legal push or pop.
  always_ff @(posedge CLK) begin
    if (!nCLR)          r_ptr <= '0;
    else if (w_do_pop)  r_ptr <= r_ptr - 1'b1;
    else if (w_do_push) r_ptr <= r_ptr + 1'b1;
  end

  // Entry storage: contents are don't-care after reset, so no clear here.
  always_ff @(posedge CLK) begin
    if (nCLR && w_do_push) r_mem[w_wr_idx] <= din;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump-load, subroutine call/return through an internal
// return-address stack, sticky stack error flag, wrap pulse and a tri-state
// bus driver. ADDR_WIDTH 2..16, BUS_WIDTH >= ADDR_WIDTH, STACK_DEPTH a power
// of two >= 2.
module pc_call_stack
  import sap_pkg::*;
#(
  parameter int ADDR_WIDTH  = SAP_ADDR_WIDTH,
  parameter int BUS_WIDTH   = SAP_BUS_WIDTH,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nCLR,
  input  logic                 Cp,
  input  logic                 Ep,
  input  logic                 Lp,
  input  logic                 Call,
  input  logic                 Ret,
  input  logic [BUS_WIDTH-1:0] bus_in,
  output logic [BUS_WIDTH-1:0] pc,
  output logic                 stk_full,
  output logic                 stk_empty,
  output logic                 stk_err,
  output logic                 wrap
);

  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_err;
  logic                  r_wrap;
  op_e                   w_op;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_top;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_unused_bus;

  // Only the low address bits of the bus carry a target.
  assign w_target     = bus_in[ADDR_WIDTH-1:0];
  assign w_unused_bus = ^bus_in;
  assign w_inc        = r_count + 1'b1;

  // Resolve simultaneous strobes to a single operation.
  always_comb begin
    w_op = OP_HOLD;
    w_op = decode_op(Cp, Lp, Call, Ret);
  end

  // The stack drops illegal pushes/pops itself; the error flag below mirrors that.
  ret_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .CLK   (CLK),
    .nCLR  (nCLR),
    .push  (w_op == OP_CALL),
    .pop   (w_op == OP_RET),
    .din   (w_inc),
    .dout  (w_top),
    .full  (w_full),
    .empty (w_empty)
  );

  // Count, sticky error and wrap pulse; reset beats every operation.
  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      r_count <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (w_op)
        OP_RET: begin
          if (w_empty) r_err   <= 1'b1;
          else         r_count <= w_top;
        end
        OP_CALL: begin
          if (w_full) r_err   <= 1'b1;
          else        r_count <= w_target;
        end
        OP_LOAD: r_count <= w_target;
        OP_INC: begin
          r_count <= w_inc;
          r_wrap  <= &r_count;
        end
        default: ;
      endcase
    end
  end

  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_err   = r_err;
  assign wrap      = r_wrap;
  assign pc        = Ep ? BUS_WIDTH'(r_count) : {BUS_WIDTH{SAP_HIZ}};

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: the driver applies one command per
// cycle and queues the expected post-edge outputs from a queue-based model;
// a monitor pops and compares one entry per clock.
module tb_pc_call_stack;

  localparam int AW = 4;
  localparam int BW = 8;
  localparam int SD = 2;

  logic          CLK = 1'b0;
  logic          nCLR = 1'b0;
  logic          Cp = 1'b0, Ep = 1'b0, Lp = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [BW-1:0] bus_in = '0;
  tri1  [BW-1:0] w_pc;   // pulled up so a floating bus reads as all ones
  logic          stk_full, stk_empty, stk_err, wrap;

  pc_call_stack #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .STACK_DEPTH(SD)) dut (
    .CLK(CLK), .nCLR(nCLR), .Cp(Cp), .Ep(Ep), .Lp(Lp), .Call(Call), .Ret(Ret),
    .bus_in(bus_in), .pc(w_pc), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_err(stk_err), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BW-1:0] pc;
    logic          full;
    logic          empty;
    logic          err;
    logic          wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txn   = 0;

  // Reference model state
  int m_count = 0;
  int m_stack[$];
  bit m_err = 0;
  bit m_wrap = 0;

  task automatic model_step(input bit nclr, input bit cp, input bit lp,
                            input bit call, input bit ret, input int bus);
    int mod;
    mod = 1 << AW;
    m_wrap = 0;
    if (!nclr) begin
      m_count = 0;
      m_stack.delete();
      m_err = 0;
    end else if (ret) begin
      if (m_stack.size() == 0) m_err = 1;
      else m_count = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == SD) m_err = 1;
      else begin
        m_stack.push_back((m_count + 1) % mod);
        m_count = bus % mod;
      end
    end else if (lp) begin
      m_count = bus % mod;
    end else if (cp) begin
      m_wrap = (m_count == mod - 1);
      m_count = (m_count + 1) % mod;
    end
  endtask

  task automatic cmd(input bit nclr, input bit cp, input bit ep, input bit lp,
                     input bit call, input bit ret, input logic [BW-1:0] bus);
    exp_t e;
    @(negedge CLK);
    nCLR = nclr; Cp = cp; Ep = ep; Lp = lp; Call = call; Ret = ret; bus_in = bus;
    model_step(nclr, cp, lp, call, ret, int'(bus));
    e.pc    = ep ? BW'(m_count) : '1;
    e.full  = (m_stack.size() == SD);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    e.wrap  = m_wrap;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", name, n_txn, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge that followed a command.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      chk("pc",        int'(w_pc),      int'(e.pc));
      chk("stk_full",  int'(stk_full),  int'(e.full));
      chk("stk_empty", int'(stk_empty), int'(e.empty));
      chk("stk_err",   int'(stk_err),   int'(e.err));
      chk("wrap",      int'(wrap),      int'(e.wrap));
      $display("[TB] txn %0d pc=%02h full=%0b empty=%0b err=%0b wrap=%0b",
               n_txn, w_pc, stk_full, stk_empty, stk_err, wrap);
    end
  end

  initial begin
    // Reset, then count through the wrap
    cmd(0, 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) cmd(1, 1, 1, 0, 0, 0, 8'h00);
    cmd(1, 0, 0, 0, 0, 0, 8'h00);              // hold, bus released
    cmd(1, 1, 1, 0, 0, 0, 8'h00);              // 2
    cmd(1, 1, 1, 0, 0, 0, 8'h00);              // 3
    cmd(1, 0, 1, 1, 0, 0, 8'hA9);              // jump, upper bits ignored
    // Nested call/return
    cmd(1, 0, 1, 1, 0, 0, 8'h05);
    cmd(1, 0, 1, 0, 1, 0, 8'h0C);
    cmd(1, 1, 1, 0, 0, 0, 8'h00);              // 0x0D
    cmd(1, 0, 1, 0, 1, 0, 8'h02);
    cmd(1, 0, 1, 0, 0, 1, 8'h00);
    cmd(1, 0, 1, 0, 0, 1, 8'h00);
    // Overflow, then sticky error across valid ops
    cmd(1, 0, 1, 0, 1, 0, 8'h03);
    cmd(1, 0, 1, 0, 1, 0, 8'h04);
    cmd(1, 0, 1, 0, 1, 0, 8'h07);
    cmd(1, 1, 1, 0, 0, 0, 8'h00);
    cmd(1, 0, 1, 0, 0, 1, 8'h00);
    cmd(1, 0, 1, 0, 0, 1, 8'h00);
    // Underflow with empty stack
    cmd(1, 0, 1, 0, 0, 1, 8'h00);
    // Call from count=max stores 0, no wrap
    cmd(0, 0, 1, 0, 0, 0, 8'h00);
    cmd(1, 0, 1, 1, 0, 0, 8'h0F);
    cmd(1, 0, 1, 0, 1, 0, 8'h08);
    cmd(1, 1, 1, 1, 1, 1, 8'h0B);              // all strobes: only Ret
    cmd(1, 0, 1, 0, 1, 0, 8'h09);
    cmd(0, 0, 1, 0, 1, 0, 8'h0A);              // reset beats Call
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rn, rc, re, rl, rca, rr;
      rn  = ($urandom_range(31) != 0);
      rc  = ($urandom_range(1) == 1);
      re  = ($urandom_range(3) != 0);
      rl  = ($urandom_range(5) == 0);
      rca = ($urandom_range(4) == 0);
      rr  = ($urandom_range(4) == 0);
      cmd(rn, rc, re, rl, rca, rr, BW'($urandom));
    end
    @(negedge CLK);
    nCLR = 1'b1; Cp = 1'b0; Lp = 1'b0; Call = 1'b0; Ret = 1'b0;
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
